cache_way_gen: RTL and testbench

Parametrised single cache way for the next-generation L1: tag/valid/dirty plus a banked data line with registered lookup, byte-enabled word writes, a multi-beat refill engine and a whole-way invalidate sweep. It sits below the cache controller FSM, which instantiates N of these for N-way associativity. Word count, word width, index and tag widths are generic.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cache_way_bank.sv | 42 ++++
 rtl/cache_way_gen.sv | 161 ++++++++++++++++
 tb/tb_cache_way_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, derived-width helpers and FSM states for one cache way.
// Imported by cache_way_bank and cache_way_gen.
package cache_pkg;

  localparam int DEF_INDEX_WIDTH    = 5;
  localparam int DEF_TAG_BITS       = 23;
  localparam int DEF_WORD_WIDTH     = 32;
  localparam int DEF_WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    FLUSH
  } way_state_t;

  function automatic int bytes_per_word(input int ww);
    return ww / 8;
  endfunction

  function automatic int word_sel(input int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int line_width(input int ww, input int wpl);
    return ww * wpl;
  endfunction

endpackage

// File: rtl/cache_way_bank.sv
// One word-wide data bank: 2^ADDR_BITS deep, registered read, byte-enabled write.
// Ports: clk, rst, en (read), we, addr, be, wdata, rdata (read-before-write).
module cache_way_bank
  import cache_pkg::*;
#(
  parameter int ADDR_BITS = DEF_INDEX_WIDTH,
  parameter int WIDTH     = DEF_WORD_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       we,
  input  logic [ADDR_BITS-1:0]       addr,
  input  logic [bytes_per_word(WIDTH)-1:0] be,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata
);

  localparam int NB = bytes_per_word(WIDTH);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

  // Storage is not reset; rdata above sees pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/cache_way_gen.sv
// Single cache way: tag/valid/dirty, banked line data, refill engine, flush sweep.
// Ports: req_* lookup/write in, rsp_* registered response, refill_*, flush_start, busy.
module cache_way_gen
  import cache_pkg::*;
#(
  parameter int INDEX_WIDTH    = DEF_INDEX_WIDTH,
  parameter int TAG_BITS       = DEF_TAG_BITS,
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_write,
  input  logic [INDEX_WIDTH-1:0]                req_index,
  input  logic [TAG_BITS-1:0]                   req_tag,
  input  logic [word_sel(WORDS_PER_LINE)-1:0]   req_word,
  input  logic [WORD_WIDTH-1:0]                 req_wdata,
  input  logic [bytes_per_word(WORD_WIDTH)-1:0] req_be,
  output logic                                  rsp_valid,
  output logic                                  rsp_hit,
  output logic                                  rsp_line_valid,
  output logic                                  rsp_dirty,
  output logic [TAG_BITS-1:0]                   rsp_tag,
  output logic [line_width(WORD_WIDTH, WORDS_PER_LINE)-1:0] rsp_line,
  input  logic                                  refill_start,
  input  logic [INDEX_WIDTH-1:0]                refill_index,
  input  logic [TAG_BITS-1:0]                   refill_tag,
  input  logic                                  refill_wvalid,
  input  logic [WORD_WIDTH-1:0]                 refill_wdata,
  output logic                                  refill_done,
  input  logic                                  flush_start,
  output logic                                  busy
);

  localparam int WSEL  = word_sel(WORDS_PER_LINE);
  localparam int BPW   = bytes_per_word(WORD_WIDTH);
  localparam int LINES = 2 ** INDEX_WIDTH;

  way_state_t state_q, state_d;

  logic [LINES-1:0]       valid_q;
  logic [LINES-1:0]       dirty_q;
  logic [TAG_BITS-1:0]    tag_mem [LINES];
  logic [INDEX_WIDTH-1:0] ridx_q;
  logic [TAG_BITS-1:0]    rtag_q;
  logic [WSEL-1:0]        beat_q;
  logic [INDEX_WIDTH-1:0] fidx_q;

  logic idle, accept, hit, wr_hit;
  logic refill_go, flush_go, beat, last_beat, flush_last;

  assign idle       = (state_q == IDLE);
  assign req_ready  = idle & ~refill_start & ~flush_start;
  assign accept     = req_ready & req_valid;
  assign refill_go  = idle & refill_start;
  assign flush_go   = idle & ~refill_start & flush_start;
  assign hit        = valid_q[req_index] & (tag_mem[req_index] == req_tag);
  assign wr_hit     = accept & req_write & hit;
  assign beat       = (state_q == REFILL) & refill_wvalid;
  assign last_beat  = beat & (beat_q == WSEL'(WORDS_PER_LINE - 1));
  assign flush_last = (state_q == FLUSH) & (fidx_q == '1);
  assign busy       = ~idle;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (refill_start)     state_d = REFILL;
        else if (flush_start) state_d = FLUSH;
      end
      REFILL: if (last_beat)  state_d = IDLE;
      FLUSH:  if (flush_last) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      dirty_q        <= '0;
      ridx_q         <= '0;
      rtag_q         <= '0;
      beat_q         <= '0;
      fidx_q         <= '0;
      rsp_valid      <= 1'b0;
      rsp_hit        <= 1'b0;
      rsp_line_valid <= 1'b0;
      rsp_dirty      <= 1'b0;
      rsp_tag        <= '0;
      refill_done    <= 1'b0;
    end else begin
      rsp_valid   <= accept;
      refill_done <= last_beat;
      if (accept) begin
        rsp_hit        <= hit;
        rsp_line_valid <= valid_q[req_index];
        rsp_dirty      <= dirty_q[req_index];
        rsp_tag        <= tag_mem[req_index];
      end
      if (wr_hit) dirty_q[req_index] <= 1'b1;
      if (refill_go) begin
        ridx_q                <= refill_index;
        rtag_q                <= refill_tag;
        beat_q                <= '0;
        valid_q[refill_index] <= 1'b0;
      end
      if (beat) beat_q <= beat_q + 1'b1;
      if (last_beat) begin
        valid_q[ridx_q] <= 1'b1;
        dirty_q[ridx_q] <= 1'b0;
      end
      if (flush_go) fidx_q <= '0;
      if (state_q == FLUSH) begin
        valid_q[fidx_q] <= 1'b0;
        dirty_q[fidx_q] <= 1'b0;
        fidx_q          <= fidx_q + 1'b1;
      end
    end
  end

  // Tags are not reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (!rst && last_beat) tag_mem[ridx_q] <= rtag_q;
  end

  // Refill and request writes never coincide: one is IDLE-only.
  logic [INDEX_WIDTH-1:0] bank_addr;
  logic [BPW-1:0]         bank_be;
  logic [WORD_WIDTH-1:0]  bank_wdata;

  assign bank_addr  = idle ? req_index : ridx_q;
  assign bank_be    = beat ? '1 : req_be;
  assign bank_wdata = beat ? refill_wdata : req_wdata;

  for (genvar w = 0; w < WORDS_PER_LINE; w++) begin : g_bank
    logic bank_we;
    assign bank_we = (wr_hit & (req_word == WSEL'(w)))
                   | (beat & (beat_q == WSEL'(w)));
    cache_way_bank #(
      .ADDR_BITS(INDEX_WIDTH),
      .WIDTH    (WORD_WIDTH)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .we   (bank_we),
      .addr (bank_addr),
      .be   (bank_be),
      .wdata(bank_wdata),
      .rdata(rsp_line[w*WORD_WIDTH +: WORD_WIDTH])
    );
  end

endmodule

// File: tb/tb_cache_way_gen.sv
// Directed and randomized bench for cache_way_gen against a line-level model.
// Drives inputs after posedge, samples #1 after the edge.
module tb_cache_way_gen;

  localparam int IW    = 5;
  localparam int TB    = 23;
  localparam int WW    = 32;
  localparam int WPL   = 4;
  localparam int WS    = 2;
  localparam int BPW   = 4;
  localparam int LW    = 128;
  localparam int LINES = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [IW-1:0] req_index;
  logic [TB-1:0] req_tag;
  logic [WS-1:0] req_word;
  logic [WW-1:0] req_wdata;
  logic [BPW-1:0] req_be;
  logic          rsp_valid, rsp_hit, rsp_line_valid, rsp_dirty;
  logic [TB-1:0] rsp_tag;
  logic [LW-1:0] rsp_line;
  logic          refill_start;
  logic [IW-1:0] refill_index;
  logic [TB-1:0] refill_tag;
  logic          refill_wvalid;
  logic [WW-1:0] refill_wdata;
  logic          refill_done, flush_start, busy;

  cache_way_gen #(
    .INDEX_WIDTH(IW), .TAG_BITS(TB),
    .WORD_WIDTH(WW), .WORDS_PER_LINE(WPL)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_index(req_index),
    .req_tag(req_tag), .req_word(req_word),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_line_valid(rsp_line_valid), .rsp_dirty(rsp_dirty),
    .rsp_tag(rsp_tag), .rsp_line(rsp_line),
    .refill_start(refill_start), .refill_index(refill_index),
    .refill_tag(refill_tag), .refill_wvalid(refill_wvalid),
    .refill_wdata(refill_wdata), .refill_done(refill_done),
    .flush_start(flush_start), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit            mvalid [LINES];
  bit            mdirty [LINES];
  bit            mknown [LINES];
  logic [TB-1:0] mtag   [LINES];
  logic [WW-1:0] mdata  [LINES][WPL];

  task automatic chk(input string name, input logic [LW-1:0] obs,
                     input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
  endtask

  function automatic logic [LW-1:0] mline(input int idx);
    logic [LW-1:0] l;
    for (int w = 0; w < WPL; w++) l[w*WW +: WW] = mdata[idx][w];
    return l;
  endfunction

  task automatic do_req(input bit wr, input int idx, input logic [TB-1:0] tg,
                        input int wd, input logic [WW-1:0] dat,
                        input logic [BPW-1:0] be);
    bit            ehit;
    bit            ev, ed, ek;
    logic [TB-1:0] et;
    logic [LW-1:0] el;
    ev   = mvalid[idx];
    ed   = mdirty[idx];
    ek   = mknown[idx];
    et   = mtag[idx];
    el   = mline(idx);
    ehit = ev && (mtag[idx] == tg);
    req_valid = 1'b1;
    req_write = wr;
    req_index = IW'(idx);
    req_tag   = tg;
    req_word  = WS'(wd);
    req_wdata = dat;
    req_be    = be;
    #1;
    chk("req_ready", LW'(req_ready), LW'(1));
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    chk("rsp_valid", LW'(rsp_valid), LW'(1));
    chk("rsp_hit", LW'(rsp_hit), LW'(ehit));
    chk("rsp_line_valid", LW'(rsp_line_valid), LW'(ev));
    chk("rsp_dirty", LW'(rsp_dirty), LW'(ed));
    if (ek) begin
      chk("rsp_tag", LW'(rsp_tag), LW'(et));
      chk("rsp_line", rsp_line, el);
    end
    if (wr && ehit) begin
      for (int b = 0; b < BPW; b++)
        if (be[b]) mdata[idx][wd][b*8 +: 8] = dat[b*8 +: 8];
      mdirty[idx] = 1'b1;
    end
  endtask

  task automatic refill(input int idx, input logic [TB-1:0] tg,
                        input logic [LW-1:0] dl, input int gap_after,
                        input bit with_req, input int abort_after);
    refill_start = 1'b1;
    refill_index = IW'(idx);
    refill_tag   = tg;
    if (with_req) begin
      req_valid = 1'b1;
      req_index = IW'(idx);
      req_tag   = tg;
    end
    #1;
    chk("ready_at_start", LW'(req_ready), LW'(0));
    tick();
    refill_start = 1'b0;
    req_valid    = 1'b0;
    chk("busy_after_start", LW'(busy), LW'(1));
    chk("no_rsp_at_start", LW'(rsp_valid), LW'(0));
    mvalid[idx] = 1'b0;
    for (int w = 0; w < WPL; w++) begin
      if (w == abort_after) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        chk("abort_done", LW'(refill_done), LW'(0));
        chk("abort_busy", LW'(busy), LW'(0));
        tick();
        chk("abort_done2", LW'(refill_done), LW'(0));
        return;
      end
      refill_wvalid = 1'b1;
      refill_wdata  = dl[w*WW +: WW];
      tick();
      refill_wvalid = 1'b0;
      mdata[idx][w] = dl[w*WW +: WW];
      if (w < WPL - 1) begin
        chk("done_early", LW'(refill_done), LW'(0));
        if (w == gap_after) begin
          tick();
          chk("busy_gap", LW'(busy), LW'(1));
        end
      end
    end
    chk("refill_done", LW'(refill_done), LW'(1));
    chk("ready_after_refill", LW'(req_ready), LW'(1));
    chk("busy_after_refill", LW'(busy), LW'(0));
    mvalid[idx] = 1'b1;
    mdirty[idx] = 1'b0;
    mknown[idx] = 1'b1;
    mtag[idx]   = tg;
    tick();
    chk("done_pulse", LW'(refill_done), LW'(0));
  endtask

  task automatic flush();
    int n;
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    n = 0;
    while (busy && n < LINES + 8) begin
      n++;
      chk("ready_in_flush", LW'(req_ready), LW'(0));
      tick();
    end
    chk("flush_cycles", LW'(n), LW'(LINES));
    model_clear();
  endtask

  initial begin
    logic [LW-1:0] d;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_index = 0; req_tag = 0;
    req_word = 0; req_wdata = 0; req_be = 0;
    refill_start = 0; refill_index = 0; refill_tag = 0;
    refill_wvalid = 0; refill_wdata = 0; flush_start = 0;
    for (int i = 0; i < LINES; i++) begin
      mknown[i] = 1'b0;
      mtag[i]   = '0;
      for (int w = 0; w < WPL; w++) mdata[i][w] = '0;
    end
    model_clear();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rsp_valid", LW'(rsp_valid), LW'(0));
    chk("rst_rsp_line", rsp_line, '0);
    chk("rst_rsp_tag", LW'(rsp_tag), LW'(0));
    chk("rst_busy", LW'(busy), LW'(0));
    chk("rst_done", LW'(refill_done), LW'(0));
    chk("rst_ready", LW'(req_ready), LW'(1));

    do_req(0, 3, 23'h12, 0, '0, '0);
    d = 128'h44444444_33333333_22222222_11111111;
    refill(3, 23'h12, d, 1, 0, -1);
    do_req(0, 3, 23'h12, 0, '0, '0);
    chk("line3", rsp_line, d);
    chk("hit3", LW'(rsp_hit), LW'(1));

    do_req(1, 3, 23'h12, 2, 32'hAAAABBBB, 4'b0011);
    chk("wr_hit", LW'(rsp_hit), LW'(1));
    do_req(0, 3, 23'h12, 0, '0, '0);
    chk("merged_word2", LW'(rsp_line[95:64]), LW'(32'h3333BBBB));
    chk("dirty_after_wr", LW'(rsp_dirty), LW'(1));

    do_req(1, 3, 23'h13, 1, 32'hDEADBEEF, 4'b1111);
    chk("miss_tag", LW'(rsp_tag), LW'(23'h12));
    chk("miss_hit", LW'(rsp_hit), LW'(0));
    do_req(0, 3, 23'h12, 0, '0, '0);

    refill(3, 23'h12, 128'h5, -1, 1, 2);
    do_req(0, 3, 23'h12, 0, '0, '0);
    chk("abort_valid", LW'(rsp_line_valid), LW'(0));

    refill(3, 23'h12, 128'hA3, -1, 0, -1);
    refill(7, 23'h40, 128'hB7, 0, 0, -1);
    do_req(1, 7, 23'h40, 1, 32'h12345678, 4'b1010);
    flush();
    do_req(0, 3, 23'h12, 0, '0, '0);
    do_req(0, 7, 23'h40, 0, '0, '0);
    chk("flush_miss7", LW'(rsp_hit), LW'(0));

    for (int it = 0; it < 300; it++) begin
      int            op, idx, tsel;
      logic [TB-1:0] tg;
      op   = int'($urandom_range(0, 99));
      idx  = int'($urandom_range(0, 7));
      tsel = int'($urandom_range(0, 2));
      tg   = (tsel == 0) ? 23'h12 : (tsel == 1) ? 23'h13 : 23'h40;
      if (op < 10) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        refill(idx, tg, d, int'($urandom_range(0, 4)), 0, -1);
      end else if (op < 11) begin
        flush();
      end else if (op < 55) begin
        do_req(1, idx, tg, int'($urandom_range(0, 3)), $urandom,
               BPW'($urandom));
      end else begin
        do_req(0, idx, tg, 0, '0, '0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
